// File: rtl/cpu_trace_pkg.sv
// Shared definitions for the CPU trace buffer: FSM state encoding,
// entry-kind tags and a helper for the packed entry width.
package cpu_trace_pkg;

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] ARMED = 3'd1;
    localparam logic [2:0] POST  = 3'd2;
    localparam logic [2:0] DONE  = 3'd3;
    localparam logic [2:0] READ  = 3'd4;

    localparam logic KIND_WB  = 1'b0;
    localparam logic KIND_MEM = 1'b1;

    // An entry is {kind, pc, tag, data}.
    function automatic int entry_width(input int pc_w, input int tag_w, input int data_w);
        return 1 + pc_w + tag_w + data_w;
    endfunction

endpackage

// File: rtl/trace_ram.sv
// Trace storage: simple dual-port RAM, synchronous write and synchronous
// read. Only the read-data register is reset; the array keeps its contents.
module trace_ram #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 41
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     re,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Write port: store one trace entry per enabled cycle.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read port: registered output that holds the last entry read.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/cpu_trace_buf.sv
// CPU trace buffer: records write-back (and optionally data-memory write)
// events into a circular buffer, stops a programmable number of events after
// a trigger PC, then streams the buffer out oldest-first.
// Optional feature macro: CPU_TRACE_MEM_EN (capture data-memory writes).
module cpu_trace_buf
    import cpu_trace_pkg::*;
#(
    parameter int PC_W   = 16,
    parameter int DATA_W = 16,
    parameter int TAG_W  = 8,
    parameter int DEPTH  = 16,
    parameter int POST_W = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              arm,
    input  logic [PC_W-1:0]                   trig_pc,
    input  logic [POST_W-1:0]                 post_cnt,
    input  logic [PC_W-1:0]                   pc,
    input  logic                              wb_en,
    input  logic [TAG_W-1:0]                  wb_idx,
    input  logic [DATA_W-1:0]                 wb_data,
    input  logic                              mem_we,
    input  logic [TAG_W-1:0]                  mem_addr,
    input  logic [DATA_W-1:0]                 mem_data,
    input  logic                              rd_req,
    output logic                              rd_valid,
    output logic [PC_W+TAG_W+DATA_W:0]        rd_entry,
    output logic [2:0]                        state_o,
    output logic [$clog2(DEPTH):0]            count,
    output logic                              overflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int EW    = entry_width(PC_W, TAG_W, DATA_W);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    logic [2:0]        state;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  cnt;
    logic [POST_W-1:0] remain;
    logic              ovf;
    logic              rd_valid_r;

    logic              mem_ev;
    logic              both_ev;
    logic [EW-1:0]     new_entry;
    logic              capturing;
    logic              cap_en;
    logic              do_read;
    logic [PTR_W-1:0]  oldest;
    logic [PTR_W-1:0]  rd_addr;

`ifdef CPU_TRACE_MEM_EN
    // Memory writes count as events; write-back wins when both fire.
    always_comb begin
        mem_ev    = mem_we;
        both_ev   = wb_en & mem_we;
        new_entry = wb_en ? {KIND_WB, pc, wb_idx, wb_data}
                          : {KIND_MEM, pc, mem_addr, mem_data};
    end
`else
    logic unused_mem;
    assign unused_mem = ^{mem_we, mem_addr, mem_data};

    // Only write-back events exist, so every entry is of the write-back kind.
    always_comb begin
        mem_ev    = 1'b0;
        both_ev   = 1'b0;
        new_entry = {KIND_WB, pc, wb_idx, wb_data};
    end
`endif

    // Decode capture and read strobes; reset and arm suppress both.
    always_comb begin
        capturing = (state == ARMED) || (state == POST);
        cap_en    = capturing && (wb_en || mem_ev) && !rst && !arm;
        oldest    = (cnt == FULL) ? wr_ptr : '0;
        rd_addr   = (state == DONE) ? oldest : rd_ptr;
        do_read   = !rst && !arm && rd_req &&
                    ((state == DONE) || ((state == READ) && (cnt != '0)));
    end

    // Capture/readout state machine with pointer, count and overflow tracking.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            cnt        <= '0;
            remain     <= '0;
            ovf        <= 1'b0;
            rd_valid_r <= 1'b0;
        end else begin
            rd_valid_r <= do_read;
            if (arm) begin
                state  <= ARMED;
                wr_ptr <= '0;
                rd_ptr <= '0;
                cnt    <= '0;
                remain <= '0;
                ovf    <= 1'b0;
            end else begin
                case (state)
                    ARMED, POST: begin
                        if (cap_en) begin
                            wr_ptr <= wr_ptr + PTR_W'(1);
                            if (cnt != FULL) begin
                                cnt <= cnt + CNT_W'(1);
                            end
                            if (both_ev) begin
                                ovf <= 1'b1;
                            end
                            if (state == ARMED) begin
                                if (pc == trig_pc) begin
                                    remain <= post_cnt;
                                    state  <= (post_cnt == '0) ? DONE : POST;
                                end
                            end else begin
                                remain <= remain - POST_W'(1);
                                if (remain == POST_W'(1)) begin
                                    state <= DONE;
                                end
                            end
                        end
                    end
                    DONE: begin
                        if (rd_req) begin
                            state  <= READ;
                            rd_ptr <= oldest + PTR_W'(1);
                            cnt    <= cnt - CNT_W'(1);
                        end
                    end
                    READ: begin
                        if (cnt == '0) begin
                            state <= IDLE;
                        end else if (rd_req) begin
                            rd_ptr <= rd_ptr + PTR_W'(1);
                            cnt    <= cnt - CNT_W'(1);
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

    trace_ram #(
        .DEPTH (DEPTH),
        .WIDTH (EW)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (cap_en),
        .waddr (wr_ptr),
        .wdata (new_entry),
        .re    (do_read),
        .raddr (rd_addr),
        .rdata (rd_entry)
    );

    assign state_o  = state;
    assign count    = cnt;
    assign overflow = ovf;
    assign rd_valid = rd_valid_r;

endmodule
